// File: rtl/decode_stage.sv
// decode_stage: registered RV32IM instruction decode with valid/ready handshake, flush and a
// trap-hold FSM (EMPTY/FULL/TRAP). Optional M-extension decode is enabled by defining
// DECODE_RVM_EN; without it any OP funct7 other than 0000000/0100000 decodes as illegal.
`ifndef MXLEN
`define MXLEN 32
`endif

module decode_stage #(
    parameter int unsigned XLEN      = `MXLEN,
    parameter int unsigned TRAP_HOLD = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      alu_ops,
    output logic            src_imm,
    output logic            branch,
    output logic            jump,
    output logic            jalr,
    output logic            lui,
    output logic            auipc,
    output logic [2:0]      pcunit_ops,
    output logic [2:0]      load_ops,
    output logic [2:0]      store_ops,
    output logic [XLEN-1:0] imm_extended,
    output logic            load,
    output logic            store,
    output logic            reg_write,
    output logic            mret,
    output logic            csr_read,
    output logic            csr_write,
    output logic            illegal_i,
    output logic            ecall_m
);

    localparam logic [4:0] ALU_ADD    = 5'd1;
    localparam logic [4:0] ALU_SUB    = 5'd2;
    localparam logic [4:0] ALU_SUB_S  = 5'd3;
    localparam logic [4:0] ALU_AND    = 5'd4;
    localparam logic [4:0] ALU_OR     = 5'd5;
    localparam logic [4:0] ALU_XOR    = 5'd6;
    localparam logic [4:0] ALU_SLL    = 5'd7;
    localparam logic [4:0] ALU_SRL    = 5'd8;
    localparam logic [4:0] ALU_SRA    = 5'd9;
    localparam logic [4:0] ALU_SLT    = 5'd10;
    localparam logic [4:0] ALU_SLTU   = 5'd11;
    localparam logic [4:0] ALU_CSRRW  = 5'd12;
`ifdef DECODE_RVM_EN
    localparam logic [4:0] ALU_MUL    = 5'd13;
    localparam logic [4:0] ALU_MULH   = 5'd14;
    localparam logic [4:0] ALU_MULHSU = 5'd15;
    localparam logic [4:0] ALU_MULHU  = 5'd16;
    localparam logic [4:0] ALU_DIV    = 5'd17;
    localparam logic [4:0] ALU_DIVU   = 5'd18;
    localparam logic [4:0] ALU_REM    = 5'd19;
    localparam logic [4:0] ALU_REMU   = 5'd20;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;
`endif

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [31:0] INSN_ECALL = 32'h0000_0073;
    localparam logic [31:0] INSN_MRET  = 32'h3020_0073;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      alu_ops;
        logic            src_imm;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic            lui;
        logic            auipc;
        logic [2:0]      pcunit_ops;
        logic [2:0]      load_ops;
        logic [2:0]      store_ops;
        logic [XLEN-1:0] imm;
        logic            load;
        logic            store;
        logic            reg_write;
        logic            mret;
        logic            csr_read;
        logic            csr_write;
        logic            illegal;
        logic            ecall;
    } bundle_t;

    typedef enum logic [1:0] {StEmpty, StFull, StTrap} state_e;

    state_e  state_q, state_d;
    logic    valid_q, valid_d;
    bundle_t bundle_q, bundle_d;
    bundle_t dec;
    logic    ill;
    logic    accept;
    logic [31:0] imm32;
    logic [4:0]  base_alu;

    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Base-ISA ALU code shared by OP-IMM and OP (funct7 = 0000000 forms).
    always_comb begin
        base_alu = ALU_ADD;
        case (funct3)
            3'd0:    base_alu = ALU_ADD;
            3'd1:    base_alu = ALU_SLL;
            3'd2:    base_alu = ALU_SLT;
            3'd3:    base_alu = ALU_SLTU;
            3'd4:    base_alu = ALU_XOR;
            3'd5:    base_alu = ALU_SRL;
            3'd6:    base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    end

    // Combinational decode of the incoming instruction into a bundle.
    always_comb begin
        dec            = '0;
        ill            = 1'b0;
        imm32          = '0;
        dec.pc         = pc_in;
        dec.rd         = instr[11:7];
        dec.rs1        = instr[19:15];
        dec.rs2        = instr[24:20];
        dec.pcunit_ops = funct3;
        dec.load_ops   = funct3;
        dec.store_ops  = funct3;
        dec.alu_ops    = ALU_ADD;
        case (instr[6:0])
            OPC_LUI:    begin dec.lui = 1'b1; dec.src_imm = 1'b1; dec.reg_write = 1'b1; imm32 = imm_u; end
            OPC_AUIPC:  begin dec.auipc = 1'b1; dec.src_imm = 1'b1; dec.reg_write = 1'b1; imm32 = imm_u; end
            OPC_JAL:    begin dec.jump = 1'b1; dec.reg_write = 1'b1; imm32 = imm_j; end
            OPC_JALR: begin
                dec.jump = 1'b1; dec.jalr = 1'b1; dec.src_imm = 1'b1; dec.reg_write = 1'b1;
                imm32 = imm_i;
                ill   = (funct3 != 3'd0);
            end
            OPC_BRANCH: begin
                dec.branch  = 1'b1;
                imm32       = imm_b;
                dec.alu_ops = (funct3[2:1] == 2'b11) ? ALU_SUB : ALU_SUB_S;
                ill         = (funct3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                dec.load = 1'b1; dec.src_imm = 1'b1; dec.reg_write = 1'b1;
                imm32 = imm_i;
                ill   = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                dec.store = 1'b1; dec.src_imm = 1'b1;
                imm32 = imm_s;
                ill   = (funct3 > 3'd2);
            end
            OPC_OP_IMM: begin
                dec.src_imm = 1'b1; dec.reg_write = 1'b1;
                imm32       = imm_i;
                dec.alu_ops = base_alu;
                if (funct3 == 3'd1) begin
                    ill = (funct7 != F7_BASE);
                end else if (funct3 == 3'd5) begin
                    if (funct7 == F7_ALT) dec.alu_ops = ALU_SRA;
                    else ill = (funct7 != F7_BASE);
                end
            end
            OPC_OP: begin
                dec.reg_write = 1'b1;
                if (funct7 == F7_BASE) dec.alu_ops = base_alu;
                else if (funct7 == F7_ALT && funct3 == 3'd0) dec.alu_ops = ALU_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'd5) dec.alu_ops = ALU_SRA;
`ifdef DECODE_RVM_EN
                else if (funct7 == F7_MULDIV) begin
                    case (funct3)
                        3'd0:    dec.alu_ops = ALU_MUL;
                        3'd1:    dec.alu_ops = ALU_MULH;
                        3'd2:    dec.alu_ops = ALU_MULHSU;
                        3'd3:    dec.alu_ops = ALU_MULHU;
                        3'd4:    dec.alu_ops = ALU_DIV;
                        3'd5:    dec.alu_ops = ALU_DIVU;
                        3'd6:    dec.alu_ops = ALU_REM;
                        default: dec.alu_ops = ALU_REMU;
                    endcase
                end
`endif
                else ill = 1'b1;
            end
            OPC_FENCE: ;  // no architectural effect in this pipeline
            OPC_SYSTEM: begin
                if (funct3 == 3'd0) begin
                    if (instr == INSN_ECALL) dec.ecall = 1'b1;
                    else if (instr == INSN_MRET) dec.mret = 1'b1;
                    else ill = 1'b1;
                end else if (funct3 == 3'd4) begin
                    ill = 1'b1;
                end else begin
                    dec.csr_read  = 1'b1;
                    dec.reg_write = (instr[11:7] != 5'd0);
                    dec.csr_write = (instr[19:15] != 5'd0);
                    dec.alu_ops   = (funct3[1:0] == 2'b01) ? ALU_CSRRW : ALU_AND;
                    dec.src_imm   = funct3[2];
                    if (funct3[2]) imm32 = {27'b0, instr[19:15]};
                end
            end
            default: ill = 1'b1;
        endcase
        // Illegal bundles carry no side effects downstream.
        if (ill) begin
            dec.src_imm   = 1'b0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
            dec.jalr      = 1'b0;
            dec.lui       = 1'b0;
            dec.auipc     = 1'b0;
            dec.load      = 1'b0;
            dec.store     = 1'b0;
            dec.reg_write = 1'b0;
            dec.mret      = 1'b0;
            dec.csr_read  = 1'b0;
            dec.csr_write = 1'b0;
            dec.ecall     = 1'b0;
            dec.alu_ops   = ALU_CSRRW;
            dec.illegal   = 1'b1;
        end
        dec.imm = XLEN'($signed(imm32));
    end

    assign in_ready = rst_n && (state_q != StTrap) && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    // Next-state logic: flush beats accept, accept beats drain.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush) begin
            state_d = StEmpty;
            valid_d = 1'b0;
        end else if (accept) begin
            bundle_d = dec;
            valid_d  = 1'b1;
            state_d  = ((TRAP_HOLD != 0) && (dec.illegal || dec.ecall)) ? StTrap : StFull;
        end else if (out_ready) begin
            valid_d = 1'b0;
            if (state_q == StFull) state_d = StEmpty;
        end
    end

    // State and bundle registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StEmpty;
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid    = valid_q;
    assign pc_out       = bundle_q.pc;
    assign rd           = bundle_q.rd;
    assign rs1          = bundle_q.rs1;
    assign rs2          = bundle_q.rs2;
    assign alu_ops      = bundle_q.alu_ops;
    assign src_imm      = bundle_q.src_imm;
    assign branch       = bundle_q.branch;
    assign jump         = bundle_q.jump;
    assign jalr         = bundle_q.jalr;
    assign lui          = bundle_q.lui;
    assign auipc        = bundle_q.auipc;
    assign pcunit_ops   = bundle_q.pcunit_ops;
    assign load_ops     = bundle_q.load_ops;
    assign store_ops    = bundle_q.store_ops;
    assign imm_extended = bundle_q.imm;
    assign load         = bundle_q.load;
    assign store        = bundle_q.store;
    assign reg_write    = bundle_q.reg_write;
    assign mret         = bundle_q.mret;
    assign csr_read     = bundle_q.csr_read;
    assign csr_write    = bundle_q.csr_write;
    assign illegal_i    = bundle_q.illegal;
    assign ecall_m      = bundle_q.ecall;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed test-plan cases plus randomized traffic scored against a
// behavioural decode/handshake model (define DECODE_RVM_EN to match an RVM build).
module tb_decode_stage;

    localparam int unsigned XLEN = 32;
    localparam int unsigned TH   = 1;

    localparam logic [4:0] A_ADD = 5'd1, A_SUB = 5'd2, A_SUB_S = 5'd3, A_AND = 5'd4;
    localparam logic [4:0] A_OR = 5'd5, A_XOR = 5'd6, A_SLL = 5'd7, A_SRL = 5'd8, A_SRA = 5'd9;
    localparam logic [4:0] A_SLT = 5'd10, A_SLTU = 5'd11, A_CSRRW = 5'd12, A_MUL = 5'd13;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2, alu;
        logic        src_imm, branch, jump, jalr, lui, auipc;
        logic [2:0]  pcu, ld, st;
        logic [31:0] imm;
        logic        load, store, reg_write, mret, csr_read, csr_write, illegal, ecall;
    } bundle_t;

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] instr = '0, pc_in = '0;
    logic in_ready, out_valid, src_imm, branch, jump, jalr, lui, auipc;
    logic load, store, reg_write, mret, csr_read, csr_write, illegal_i, ecall_m;
    logic [31:0] pc_out, imm_extended;
    logic [4:0] rd, rs1, rs2, alu_ops;
    logic [2:0] pcunit_ops, load_ops, store_ops;

    decode_stage #(.XLEN(XLEN), .TRAP_HOLD(TH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .pc_in(pc_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .rd(rd), .rs1(rs1), .rs2(rs2), .alu_ops(alu_ops), .src_imm(src_imm),
        .branch(branch), .jump(jump), .jalr(jalr), .lui(lui), .auipc(auipc),
        .pcunit_ops(pcunit_ops), .load_ops(load_ops), .store_ops(store_ops),
        .imm_extended(imm_extended), .load(load), .store(store), .reg_write(reg_write),
        .mret(mret), .csr_read(csr_read), .csr_write(csr_write), .illegal_i(illegal_i),
        .ecall_m(ecall_m)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decode written from the ISA rules with plain arithmetic.
    function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        bundle_t b;
        logic [31:0] sgn, i_imm, s_imm, b_imm, u_imm, j_imm;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [4:0] alu_tab [8];
        logic bad;
        alu_tab = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        sgn   = ins[31] ? 32'hFFFF_FFFF : 32'h0;
        i_imm = (sgn << 11) | 32'(ins[30:20]);
        s_imm = (sgn << 11) | (32'(ins[30:25]) << 5) | 32'(ins[11:7]);
        b_imm = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        u_imm = ins & 32'hFFFF_F000;
        j_imm = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        b = '0; bad = 1'b0;
        b.pc = pc; b.rd = ins[11:7]; b.rs1 = ins[19:15]; b.rs2 = ins[24:20];
        b.pcu = f3; b.ld = f3; b.st = f3; b.alu = A_ADD;
        case (op)
            7'h37: begin b.lui = 1; b.src_imm = 1; b.reg_write = 1; b.imm = u_imm; end
            7'h17: begin b.auipc = 1; b.src_imm = 1; b.reg_write = 1; b.imm = u_imm; end
            7'h6F: begin b.jump = 1; b.reg_write = 1; b.imm = j_imm; end
            7'h67: begin
                b.jump = 1; b.jalr = 1; b.src_imm = 1; b.reg_write = 1; b.imm = i_imm;
                bad = (f3 != 0);
            end
            7'h63: begin
                b.branch = 1; b.imm = b_imm;
                b.alu = (f3 == 6 || f3 == 7) ? A_SUB : A_SUB_S;
                bad = (f3 == 2 || f3 == 3);
            end
            7'h03: begin
                b.load = 1; b.src_imm = 1; b.reg_write = 1; b.imm = i_imm;
                bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            end
            7'h23: begin b.store = 1; b.src_imm = 1; b.imm = s_imm; bad = (f3 > 2); end
            7'h13: begin
                b.src_imm = 1; b.reg_write = 1; b.imm = i_imm; b.alu = alu_tab[f3];
                if (f3 == 5 && f7 == 7'h20) b.alu = A_SRA;
                if (f3 == 1) bad = (f7 != 0);
                if (f3 == 5) bad = !(f7 == 0 || f7 == 7'h20);
            end
            7'h33: begin
                b.reg_write = 1;
                if (f7 == 0) b.alu = alu_tab[f3];
                else if (f7 == 7'h20 && f3 == 0) b.alu = A_SUB;
                else if (f7 == 7'h20 && f3 == 5) b.alu = A_SRA;
`ifdef DECODE_RVM_EN
                else if (f7 == 7'h01) b.alu = A_MUL + 5'(f3);
`endif
                else bad = 1;
            end
            7'h0F: ;
            7'h73: begin
                if (f3 == 0) begin
                    if (ins == 32'h73) b.ecall = 1;
                    else if (ins == 32'h3020_0073) b.mret = 1;
                    else bad = 1;
                end else if (f3 == 4) begin
                    bad = 1;
                end else begin
                    b.csr_read = 1;
                    b.reg_write = (ins[11:7] != 0);
                    b.csr_write = (ins[19:15] != 0);
                    b.alu = (f3 == 1 || f3 == 5) ? A_CSRRW : A_AND;
                    b.src_imm = (f3 >= 5);
                    b.imm = (f3 >= 5) ? 32'(ins[19:15]) : 32'h0;
                end
            end
            default: bad = 1;
        endcase
        if (bad) begin
            {b.src_imm, b.branch, b.jump, b.jalr, b.lui, b.auipc} = '0;
            {b.load, b.store, b.reg_write, b.mret, b.csr_read, b.csr_write, b.ecall} = '0;
            b.alu = A_CSRRW;
            b.illegal = 1;
        end
        return b;
    endfunction

    bundle_t dut_b;
    always_comb begin
        dut_b = '{pc: pc_out, rd: rd, rs1: rs1, rs2: rs2, alu: alu_ops, src_imm: src_imm,
                  branch: branch, jump: jump, jalr: jalr, lui: lui, auipc: auipc,
                  pcu: pcunit_ops, ld: load_ops, st: store_ops, imm: imm_extended,
                  load: load, store: store, reg_write: reg_write, mret: mret,
                  csr_read: csr_read, csr_write: csr_write, illegal: illegal_i,
                  ecall: ecall_m};
    end

    // Scoreboard: queue of decoded bundles awaiting consumption, plus a trap-hold flag.
    bundle_t sb_q[$];
    logic m_trap = 1'b0;
    logic m_zero = 1'b1;
    always @(negedge clk) begin
        bundle_t nb;
        logic exp_rdy;
        if (!rst_n) begin
            check("in_ready_rst", in_ready, 1'b0);
            sb_q.delete();
            m_trap = 1'b0;
            m_zero = 1'b1;
        end else begin
            exp_rdy = !m_trap && (sb_q.size() == 0 || out_ready);
            check("in_ready", in_ready, exp_rdy);
            check("out_valid", out_valid, sb_q.size() != 0);
            if (sb_q.size() != 0) check("bundle", dut_b, sb_q[0]);
            else if (m_zero) check("bundle_rst", dut_b, '0);
            if (flush) begin
                sb_q.delete();
                m_trap = 1'b0;
            end else begin
                if (sb_q.size() != 0 && out_ready) void'(sb_q.pop_front());
                if (in_valid && exp_rdy) begin
                    nb = ref_decode(instr, pc_in);
                    sb_q.push_back(nb);
                    m_zero = 1'b0;
                    m_trap = (TH != 0) && (nb.illegal || nb.ecall);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [12];
        logic [31:0] r;
        int k;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73,
                7'h00};
        r = $urandom;
        k = $urandom_range(0, 11);
        r[6:0] = (k == 11) ? 7'($urandom) : ops[k];
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: ;
        endcase
        if (r[6:0] == 7'h73 && $urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 2))
                0: r = 32'h0000_0073;
                1: r = 32'h3020_0073;
                default: r = 32'h0010_0073;
            endcase
        end
        return r;
    endfunction

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_alu", alu_ops, 5'd0);
        check("rst_imm", imm_extended, 32'h0);
        check("rst_pc", pc_out, 32'h0);
        rst_n = 1'b1;

        // addi x1,x0,-1
        in_valid = 1'b1; instr = 32'hFFF0_0093; pc_in = 32'h100; out_ready = 1'b1;
        step();
        check("addi_valid", out_valid, 1'b1);
        check("addi_alu", alu_ops, A_ADD);
        check("addi_src_imm", src_imm, 1'b1);
        check("addi_imm", imm_extended, 32'hFFFF_FFFF);
        check("addi_rd", rd, 5'd1);
        check("addi_we", reg_write, 1'b1);
        check("addi_pc", pc_out, 32'h100);

        // beq x0,x0,-4 then jal x1,8 back to back
        instr = 32'hFE00_0EE3; pc_in = 32'h104;
        step();
        check("beq_branch", branch, 1'b1);
        check("beq_alu", alu_ops, A_SUB_S);
        check("beq_imm", imm_extended, 32'hFFFF_FFFC);
        check("beq_we", reg_write, 1'b0);
        instr = 32'h0080_00EF; pc_in = 32'h108;
        step();
        check("jal_jump", jump, 1'b1);
        check("jal_imm", imm_extended, 32'h8);
        check("jal_rd", rd, 5'd1);

        // Stall for three cycles with a new instruction waiting
        out_ready = 1'b0; instr = 32'h0010_0113; pc_in = 32'h10C;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_in_ready", in_ready, 1'b0);
            step();
            check("stall_pc", pc_out, 32'h108);
            check("stall_jump", jump, 1'b1);
        end
        out_ready = 1'b1;
        #1 check("unstall_in_ready", in_ready, 1'b1);
        step();
        check("unstall_pc", pc_out, 32'h10C);
        check("unstall_rd", rd, 5'd2);
        in_valid = 1'b0;
        step();
        check("drain_valid", out_valid, 1'b0);

        // mul x3,x1,x2
        in_valid = 1'b1; instr = 32'h0220_81B3; pc_in = 32'h200;
        step();
        in_valid = 1'b0;
`ifdef DECODE_RVM_EN
        check("mul_alu", alu_ops, A_MUL);
        check("mul_we", reg_write, 1'b1);
        check("mul_ill", illegal_i, 1'b0);
`else
        check("mul_ill", illegal_i, 1'b1);
        check("mul_we", reg_write, 1'b0);
`endif
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("mul_flush_valid", out_valid, 1'b0);

        // ecall holds the stage until flush
        in_valid = 1'b1; instr = 32'h0000_0073; pc_in = 32'h300;
        step();
        check("ecall_m", ecall_m, 1'b1);
        check("ecall_ill", illegal_i, 1'b0);
        instr = 32'h0010_0113; pc_in = 32'h304;
        #1 check("trap_in_ready0", in_ready, 1'b0);
        step();
        check("trap_valid_drop", out_valid, 1'b0);
        check("trap_pc_hold", pc_out, 32'h300);
        #1 check("trap_in_ready1", in_ready, 1'b0);
        step();
        check("trap_in_ready2", in_ready, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1 check("flush_in_ready", in_ready, 1'b1);
        instr = 32'h3020_0073; pc_in = 32'h308;
        step();
        check("mret", mret, 1'b1);
        check("mret_ecall", ecall_m, 1'b0);
        check("mret_pc", pc_out, 32'h308);

        // flush together with a new instruction while FULL
        instr = 32'h0050_0293; pc_in = 32'h30C; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", out_valid, 1'b0);
        step();
        check("flush_dropped_valid", out_valid, 1'b0);
        check("flush_dropped_pc", pc_out, 32'h308);

        // reset while in TRAP
        in_valid = 1'b1; instr = 32'h0000_0073; pc_in = 32'h400;
        step();
        check("trap2_ecall", ecall_m, 1'b1);
        in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
        step();
        check("rst_trap_valid", out_valid, 1'b0);
        check("rst_trap_ecall", ecall_m, 1'b0);
        check("rst_trap_pc", pc_out, 32'h0);
        check("rst_trap_alu", alu_ops, 5'd0);
        check("rst_trap_imm", imm_extended, 32'h0);
        rst_n = 1'b1;
        #1 check("rst_trap_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;

        // Randomized traffic, scored by the negedge model
        for (int i = 0; i < 4000; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            instr     = rand_instr();
            pc_in     = $urandom & 32'hFFFF_FFFC;
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
